n64_pi_host: RTL and testbench

N64_PI_HOST -- requirements
Module: n64_pi_host

---
 rtl/n64_pi_pkg.sv | 19 +
 rtl/n64_pi_host_timer.sv | 30 +++
 rtl/n64_pi_host.sv | 184 ++++++++++++++++++
 tb/tb_n64_pi_host.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pi_pkg.sv
// N64 PI host shared definitions.
// Bus mode encodings {aleh,alel} and the host FSM state type.
package n64_pi_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b10;
  localparam logic [1:0] MODE_HIGH  = 2'b11;
  localparam logic [1:0] MODE_LOW   = 2'b01;
  localparam logic [1:0] MODE_VALID = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HIGH,
    S_ADDR_LOW,
    S_ADDR_VALID,
    S_PULSE,
    S_GAP
  } host_state_e;

endpackage

// File: rtl/n64_pi_host_timer.sv
// Phase timer: loadable 8-bit down-counter, holds at zero.
// Ports: clk_i, rst_i (sync high), load_i/value_i, count_o, done_o (count==0).
module n64_pi_host_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic [7:0] count_o,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == 8'd0);

endmodule

// File: rtl/n64_pi_host.sv
// N64 Parallel Interface host: ALE address phases then READ/WRITE bursts.
// Ports: i_clk, i_reset, i_request/i_write/i_address/i_length/i_data in;
// o_busy, o_ack, o_data, PI strobes out; io_n64_pi_ad bidirectional.
module n64_pi_host
  import n64_pi_pkg::*;
#(
  parameter int unsigned T_ALE   = 8,
  parameter int unsigned T_PULSE = 16,
  parameter int unsigned T_GAP   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_write,
  input  logic [31:0] i_address,
  input  logic [7:0]  i_length,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_n64_pi_aleh,
  output logic        o_n64_pi_alel,
  output logic        o_n64_pi_read,
  output logic        o_n64_pi_write,
  inout  wire  [15:0] io_n64_pi_ad
);

  localparam logic [7:0] LD_ALE   = 8'(T_ALE - 1);
  localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

  host_state_e state_q, state_d;
  logic [31:1] addr_q;
  logic        write_q;
  logic [15:0] hw_cnt_q, hw_cnt_d;
  logic [31:0] wdata_q, data_q;
  logic [15:0] rhi_q, rlo_q;

  logic       tmr_ld, tmr_done;
  logic [7:0] tmr_val, tmr_cnt;

  logic [1:0]  mode;
  logic        ad_oe;
  logic [15:0] ad_out;
  logic        first_cyc, hi_sel;
  logic [31:0] wword;
  logic        unused_addr0;

  assign unused_addr0 = i_address[0];

  n64_pi_host_timer u_timer (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .load_i  (tmr_ld),
    .value_i (tmr_val),
    .count_o (tmr_cnt),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    hw_cnt_d = hw_cnt_q;
    tmr_ld   = 1'b0;
    tmr_val  = LD_ALE;
    unique case (state_q)
      S_IDLE: if (i_request) begin
        state_d  = S_ADDR_HIGH;
        tmr_ld   = 1'b1;
        hw_cnt_d = (i_length == 8'd0) ? 16'd512
                 : {7'd0, i_length, 1'b0};
      end
      S_ADDR_HIGH: if (tmr_done) begin
        state_d = S_ADDR_LOW;
        tmr_ld  = 1'b1;
      end
      S_ADDR_LOW: if (tmr_done) begin
        state_d = S_ADDR_VALID;
        tmr_ld  = 1'b1;
      end
      S_ADDR_VALID: if (tmr_done) begin
        state_d = S_PULSE;
        tmr_ld  = 1'b1;
        tmr_val = LD_PULSE;
      end
      S_PULSE: if (tmr_done) begin
        state_d  = S_GAP;
        tmr_ld   = 1'b1;
        tmr_val  = LD_GAP;
        hw_cnt_d = hw_cnt_q - 16'd1;
      end
      S_GAP: if (tmr_done) begin
        if (hw_cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PULSE;
          tmr_ld  = 1'b1;
          tmr_val = LD_PULSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter is even before a word's first pulse and odd before its
  // second, so bit 0 tells which halfword is on the bus.
  assign first_cyc = (state_q == S_PULSE) && (tmr_cnt == LD_PULSE)
                   && !hw_cnt_q[0];
  assign hi_sel = (state_q == S_PULSE) ^ hw_cnt_q[0];
  // First pulse cycle drives i_data directly; it is latched that edge.
  assign wword  = first_cyc ? i_data : wdata_q;

  assign o_ack = (state_q == S_GAP) && tmr_done && !hw_cnt_q[0];
  assign o_data = (o_ack && !write_q) ? {rhi_q, rlo_q} : data_q;

  always_comb begin
    mode           = MODE_IDLE;
    o_busy         = 1'b1;
    o_n64_pi_read  = 1'b1;
    o_n64_pi_write = 1'b1;
    ad_oe          = 1'b0;
    ad_out         = {addr_q[15:1], 1'b0};
    unique case (state_q)
      S_IDLE: o_busy = 1'b0;
      S_ADDR_HIGH: begin
        mode   = MODE_HIGH;
        ad_oe  = 1'b1;
        ad_out = addr_q[31:16];
      end
      S_ADDR_LOW: begin
        mode  = MODE_LOW;
        ad_oe = 1'b1;
      end
      S_ADDR_VALID: begin
        mode  = MODE_VALID;
        ad_oe = write_q;
      end
      S_PULSE: begin
        mode           = MODE_VALID;
        o_n64_pi_read  = write_q;
        o_n64_pi_write = !write_q;
        ad_oe          = write_q;
        ad_out         = hi_sel ? wword[31:16] : wword[15:0];
      end
      S_GAP: begin
        mode   = MODE_VALID;
        ad_oe  = write_q;
        ad_out = hi_sel ? wword[31:16] : wword[15:0];
      end
      default: o_busy = 1'b0;
    endcase
  end

  assign {o_n64_pi_aleh, o_n64_pi_alel} = mode;
  assign io_n64_pi_ad = ad_oe ? ad_out : 16'hzzzz;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      hw_cnt_q <= 16'd0;
      wdata_q  <= 32'd0;
      rhi_q    <= 16'd0;
      rlo_q    <= 16'd0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      hw_cnt_q <= hw_cnt_d;
      if (state_q == S_IDLE && i_request) begin
        addr_q  <= i_address[31:1];
        write_q <= i_write;
      end
      if (first_cyc && write_q)
        wdata_q <= i_data;
      if (state_q == S_PULSE && tmr_done && !write_q) begin
        if (!hw_cnt_q[0]) rhi_q <= io_n64_pi_ad;
        else              rlo_q <= io_n64_pi_ad;
      end
      if (o_ack && !write_q)
        data_q <= {rhi_q, rlo_q};
    end
  end

endmodule

// File: tb/tb_n64_pi_host.sv
// Scoreboard bench for n64_pi_host with a simple PI target model.
// Stimulus queues expected bus/ack events; a negedge monitor compares.
module tb_n64_pi_host;

  typedef enum logic [1:0] {EV_AH, EV_AL, EV_WH, EV_ACK} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic [31:0] val;
    logic        chk;
  } ev_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_request = 1'b0;
  logic        i_write = 1'b0;
  logic [31:0] i_address = 32'd0;
  logic [7:0]  i_length = 8'd0;
  logic [31:0] i_data;
  logic        o_busy, o_ack;
  logic [31:0] o_data;
  logic        aleh, alel, rd_n, wr_n;
  wire  [15:0] pi_ad;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  int          rd_base = 0;
  int          ack_cnt = 0;
  int          wr_base = 0;
  logic [15:0] rd_hw [512];
  logic [31:0] wr_words [4];
  logic        probe_en = 1'b0;
  logic [1:0]  pmode = 2'b10;
  logic        prd = 1'b1;
  logic        pwr = 1'b1;
  logic [8:0]  rd_idx;
  logic [1:0]  wr_idx;

  always #5 clk = ~clk;

  assign rd_idx = 9'(rd_cnt - rd_base);
  assign wr_idx = 2'(ack_cnt - wr_base);
  assign i_data = wr_words[wr_idx];
  assign pi_ad  = probe_en ? 16'h5A5A
                : (!rd_n ? rd_hw[rd_idx] : 16'hzzzz);

  n64_pi_host #(.T_ALE(2), .T_PULSE(6), .T_GAP(3)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_request      (i_request),
    .i_write        (i_write),
    .i_address      (i_address),
    .i_length       (i_length),
    .i_data         (i_data),
    .o_busy         (o_busy),
    .o_ack          (o_ack),
    .o_data         (o_data),
    .o_n64_pi_aleh  (aleh),
    .o_n64_pi_alel  (alel),
    .o_n64_pi_read  (rd_n),
    .o_n64_pi_write (wr_n),
    .io_n64_pi_ad   (pi_ad)
  );

  task automatic push(input ev_e k, input logic [31:0] v,
                      input logic c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.chk  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_e k, input logic [31:0] v);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got %s %h, required no event",
               k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (e.chk && e.val != v)) begin
        n_fail++;
        $display("FAIL sb_event: got %s %h, required %s %h",
                 k.name(), v, e.kind.name(), e.val);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    if ({aleh, alel} == 2'b11 && pmode != 2'b11) observe(EV_AH, 32'(pi_ad));
    if ({aleh, alel} == 2'b01 && pmode != 2'b01) observe(EV_AL, 32'(pi_ad));
    if (!pwr && wr_n && o_busy) observe(EV_WH, 32'(pi_ad));
    if (o_ack) begin
      observe(EV_ACK, o_data);
      ack_cnt++;
    end
    if (!prd && rd_n) rd_cnt++;
    pmode = {aleh, alel};
    prd   = rd_n;
    pwr   = wr_n;
  end

  task automatic start(input logic wr, input logic [31:0] a,
                       input logic [7:0] len);
    @(negedge clk);
    i_request = 1'b1;
    i_write   = wr;
    i_address = a;
    i_length  = len;
    @(negedge clk);
    i_request = 1'b0;
    check("busy_rise", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(o_busy), 32'd0);
  endtask

  int r0, a0, n;

  initial begin
    wr_words[0] = 32'd0; wr_words[1] = 32'd0;
    wr_words[2] = 32'd0; wr_words[3] = 32'd0;
    for (int i = 0; i < 512; i++) rd_hw[i] = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_mode", 32'({aleh, alel}), 32'd2);
    check("rst_read", 32'(rd_n), 32'd1);
    check("rst_write", 32'(wr_n), 32'd1);
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_data", o_data, 32'd0);
    i_reset = 1'b0;

    // single word read
    rd_hw[0] = 16'hDEAD; rd_hw[1] = 16'hBEEF;
    rd_base = rd_cnt; r0 = rd_cnt; a0 = ack_cnt;
    push(EV_AH, 32'h1000, 1'b1);
    push(EV_AL, 32'h0000, 1'b1);
    push(EV_ACK, 32'hDEADBEEF, 1'b1);
    start(1'b0, 32'h1000_0000, 8'd1);
    wait_idle("rd1_idle");
    check("rd1_pulses", 32'(rd_cnt - r0), 32'd2);
    check("rd1_acks", 32'(ack_cnt - a0), 32'd1);
    check("rd1_hold", o_data, 32'hDEADBEEF);

    // two word write
    wr_words[0] = 32'h1234_5678; wr_words[1] = 32'h9ABC_DEF0;
    wr_base = ack_cnt; a0 = ack_cnt;
    push(EV_AH, 32'h0800, 1'b1);
    push(EV_AL, 32'h0002, 1'b1);
    push(EV_WH, 32'h1234, 1'b1);
    push(EV_WH, 32'h5678, 1'b1);
    push(EV_ACK, 32'h0, 1'b0);
    push(EV_WH, 32'h9ABC, 1'b1);
    push(EV_WH, 32'hDEF0, 1'b1);
    push(EV_ACK, 32'h0, 1'b0);
    start(1'b1, 32'h0800_0002, 8'd2);
    wait_idle("wr2_idle");
    check("wr2_acks", 32'(ack_cnt - a0), 32'd2);

    // odd address: bit 0 never driven
    rd_hw[0] = 16'hCAFE; rd_hw[1] = 16'hF00D;
    rd_base = rd_cnt;
    push(EV_AH, 32'h1000, 1'b1);
    push(EV_AL, 32'h0002, 1'b1);
    push(EV_ACK, 32'hCAFEF00D, 1'b1);
    start(1'b0, 32'h1000_0003, 8'd1);
    wait_idle("odd_idle");

    // length 0 = 256 words
    for (int i = 0; i < 512; i++) rd_hw[i] = 16'(i * 7 + 256);
    rd_base = rd_cnt; r0 = rd_cnt; a0 = ack_cnt;
    push(EV_AH, 32'h1000, 1'b1);
    push(EV_AL, 32'h0400, 1'b1);
    for (int k = 0; k < 256; k++)
      push(EV_ACK, {rd_hw[2*k], rd_hw[2*k+1]}, 1'b1);
    start(1'b0, 32'h1000_0400, 8'd0);
    wait_idle("len0_idle");
    check("len0_pulses", 32'(rd_cnt - r0), 32'd512);
    check("len0_acks", 32'(ack_cnt - a0), 32'd256);

    // request held high while busy
    rd_hw[0] = 16'h1111; rd_hw[1] = 16'h2222;
    rd_hw[2] = 16'h3333; rd_hw[3] = 16'h4444;
    rd_base = rd_cnt; r0 = rd_cnt; a0 = ack_cnt;
    push(EV_AH, 32'h2000, 1'b1);
    push(EV_AL, 32'h0000, 1'b1);
    push(EV_ACK, 32'h11112222, 1'b1);
    push(EV_AH, 32'h2000, 1'b1);
    push(EV_AL, 32'h0000, 1'b1);
    push(EV_ACK, 32'h33334444, 1'b1);
    @(negedge clk);
    i_request = 1'b1; i_write = 1'b0;
    i_address = 32'h2000_0000; i_length = 8'd1;
    @(negedge clk);
    check("hold_busy1", 32'(o_busy), 32'd1);
    wait_idle("hold_idle1");
    check("hold_acks1", 32'(ack_cnt - a0), 32'd1);
    @(negedge clk);
    check("hold_busy2", 32'(o_busy), 32'd1);
    i_request = 1'b0;
    wait_idle("hold_idle2");
    check("hold_pulses", 32'(rd_cnt - r0), 32'd4);
    check("hold_acks2", 32'(ack_cnt - a0), 32'd2);

    // reset in 5th write pulse cycle
    wr_words[0] = 32'hAAAA_5555; wr_words[1] = 32'h0F0F_F0F0;
    wr_base = ack_cnt; a0 = ack_cnt;
    push(EV_AH, 32'h0800, 1'b1);
    push(EV_AL, 32'h0002, 1'b1);
    start(1'b1, 32'h0800_0002, 8'd2);
    n = 0;
    while (wr_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_wr_fell", 32'(wr_n), 32'd0);
    repeat (4) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("abort_write", 32'(wr_n), 32'd1);
    check("abort_read", 32'(rd_n), 32'd1);
    check("abort_mode", 32'({aleh, alel}), 32'd2);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_ack", 32'(o_ack), 32'd0);
    check("abort_data", o_data, 32'd0);
    probe_en = 1'b1;
    #1;
    check("abort_ad_z", 32'(pi_ad), 32'h5A5A);
    probe_en = 1'b0;
    i_reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
